// File: rtl/rcs_div8_ctrl_if.sv
// Handshake and data bundle between a requester (master) and the divider (slave).
interface rcs_div8_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/rcs_div8_ctrl.sv
// 8-bit restoring divider: one quotient bit per clock through a shared ripple-carry subtractor.
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_CALC | eight shift/subtract iterations, cnt counts 0..7
// S_FIN  | publish quotient/remainder/dbz, pulse done
module rcs_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_start,
    output logic [7:0] sum,
    output logic       carry
);
    // a - b computed as a + ~b + carry_start; carry=1 means no borrow
    always_comb begin
        logic c;
        sum = '0;
        c   = carry_start;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ ~b[i] ^ c;
            c      = (a[i] & ~b[i]) | (c & (a[i] ^ ~b[i]));
        end
        carry = c;
    end
endmodule

module rcs_div8_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rcs_div8_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [3:0]       r_cnt;
    logic             r_dbz_pend;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_diff;
    logic             w_carry;
    logic             w_qb;

    assign w_s  = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    // a bit shifted out of R means the true value is >= 256 > D, so subtract regardless
    assign w_qb = r_rem[WIDTH-1] | w_carry;

    rcs_8bit u_sub (
        .a           (w_s),
        .b           (r_d),
        .carry_start (1'b1),
        .sum         (w_diff),
        .carry       (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_dbz_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.divisor != '0) begin
                            r_rem      <= '0;
                            r_q        <= bus.dividend;
                            r_d        <= bus.divisor;
                            r_cnt      <= '0;
                            r_dbz_pend <= 1'b0;
                            r_state    <= S_CALC;
                        end else begin
                            r_rem      <= bus.dividend;
                            r_q        <= '1;
                            r_dbz_pend <= 1'b1;
                            r_state    <= S_FIN;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_qb ? w_diff : w_s;
                    r_q   <= {r_q[WIDTH-2:0], w_qb};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_quotient  <= r_q;
                    r_remainder <= r_rem;
                    r_dbz       <= r_dbz_pend;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.dbz       = r_dbz;
endmodule

// File: tb/tb_rcs_div8_ctrl.sv
// Scoreboard bench for rcs_div8_ctrl: directed cases plus a random sweep against an arithmetic model.
module tb_rcs_div8_ctrl;
    logic clk;
    logic rst_n;

    rcs_div8_ctrl_if bus ();

    rcs_div8_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n;
        int d;
        int q;
        int r;
        int dbz;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   busy_run = 0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain integer division; divide-by-zero returns all-ones and the dividend.
    function automatic exp_t model(input int n, input int d);
        exp_t e;
        e.n = n;
        e.d = d;
        if (d == 0) begin
            e.q = 255; e.r = n; e.dbz = 1; e.lat = 1;
        end else begin
            e.q = n / d; e.r = n % d; e.dbz = 0; e.lat = 9;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (bus.busy) busy_run++;
                if (bus.done) begin
                    chk("busy_with_done", int'(bus.busy), 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("quotient %0d/%0d", e.n, e.d), int'(bus.quotient), e.q);
                        chk($sformatf("remainder %0d/%0d", e.n, e.d), int'(bus.remainder), e.r);
                        chk($sformatf("dbz %0d/%0d", e.n, e.d), int'(bus.dbz), e.dbz);
                        chk($sformatf("busy_cycles %0d/%0d", e.n, e.d), busy_run, e.lat);
                        if (e.d != 0)
                            chk($sformatf("identity %0d/%0d", e.n, e.d),
                                int'((bus.quotient * e.d + bus.remainder == e.n) && (bus.remainder < e.d)), 1);
                    end
                    busy_run = 0;
                end
            end
        end
    end

    // Waits (bounded) for the DUT to be idle, then presents a one-cycle start.
    task automatic issue(input int n, input int d, input bit push);
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 1, 0);
        bus.start    = 1'b1;
        bus.dividend = 8'(n);
        bus.divisor  = 8'(d);
        if (push) sb.push_back(model(n, d));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom_range(0, 255));
        bus.divisor  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.done && cycles < 60);
        if (!bus.done) chk("done_timeout", cycles, -1);
    endtask

    int lat;
    int n;
    int d;

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_quotient", int'(bus.quotient), 0);
        chk("reset_remainder", int'(bus.remainder), 0);
        chk("reset_dbz", int'(bus.dbz), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(200, 7, 1'b1);
        wait_done(lat);
        chk("latency_200_7", lat, 9);

        issue(255, 128, 1'b1);
        issue(255, 1, 1'b1);
        issue(5, 9, 1'b1);
        issue(200, 200, 1'b1);
        issue(0, 37, 1'b1);

        issue(13, 0, 1'b1);
        wait_done(lat);
        chk("latency_dbz", lat, 1);
        issue(10, 3, 1'b1);
        wait_done(lat);

        // start during CALC is dropped; a held start is taken right after done
        issue(100, 9, 1'b1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        sb.push_back(model(50, 5));
        wait_done(lat);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        chk("held_start_interval", lat + 1, 10);

        // asynchronous abort mid-division
        issue(250, 3, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_quotient", int'(bus.quotient), 0);
        chk("abort_remainder", int'(bus.remainder), 0);
        chk("abort_dbz", int'(bus.dbz), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(250, 3, 1'b1);
        wait_done(lat);

        issue(0, 0, 1'b1);
        issue(255, 255, 1'b1);
        issue(128, 255, 1'b1);
        issue(255, 0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            n = int'($urandom_range(0, 255));
            d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            issue(n, d, 1'b1);
        end

        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end
endmodule
